// File: rtl/mult_product_accumulator.sv
// Multiply-accumulate stage behind the 4x4 array multiplier: sums a batch of 8-bit products.
// Optional build macro MULT_ACC_SATURATE_EN clamps the sum at 2^ACC_W-1 instead of wrapping.
module mult_product_accumulator #(
   parameter int unsigned ACC_W = 16,
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [LEN_W-1:0] acc_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             overflow,
   output logic             busy
);

   localparam int unsigned SUM_W = ACC_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] eff_len;
   logic [SUM_W-1:0] sum;
   logic [ACC_W-1:0] next_acc;
   logic             carry;
   logic             in_xfer;

   // A zero length request still forms a batch of one product.
   assign eff_len = (acc_len == '0) ? LEN_W'(1) : acc_len;

   assign in_ready = (state != HOLD);
   assign in_xfer  = in_valid & in_ready;

   always_comb begin
      sum   = {1'b0, acc_out} + SUM_W'(prod);
      carry = sum[ACC_W];
`ifdef MULT_ACC_SATURATE_EN
      next_acc = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      next_acc = sum[ACC_W-1:0];
`endif
   end

   // Batch control; clear outranks both handshakes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc_out   <= '0;
         overflow  <= 1'b0;
         cnt       <= '0;
         len       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else if (clear) begin
         state     <= IDLE;
         acc_out   <= '0;
         overflow  <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_xfer) begin
                  acc_out  <= ACC_W'(prod);
                  cnt      <= LEN_W'(1);
                  len      <= eff_len;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
                  if (eff_len == LEN_W'(1)) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (in_xfer) begin
                  acc_out  <= next_acc;
                  overflow <= overflow | carry;
                  cnt      <= cnt + LEN_W'(1);
                  if (cnt + LEN_W'(1) == len) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Directed bench for mult_product_accumulator built with ACC_W=10 so the overflow case is reachable.
module tb_mult_product_accumulator;

   localparam int unsigned ACC_W = 10;
   localparam int unsigned LEN_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             clear;
   logic [LEN_W-1:0] acc_len;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       prod;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_out;
   logic             overflow;
   logic             busy;

   int vectors = 0;
   int miscompares = 0;

   mult_product_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .clear(clear), .acc_len(acc_len),
      .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
      .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
      .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; acc_len = '0; in_valid = 1'b0; prod = '0; out_ready = 1'b0;
      #12;
      vectors++;
      if ({busy, out_valid, overflow, acc_out} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got busy=%b ov=%b ovf=%b acc=%0d need all zero",
                  busy, out_valid, overflow, acc_out);
      end
      rst = 1'b0;
      step();
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready got %b need 1", in_ready);
      end
   endtask

   task automatic test_batch4();
      acc_len = 4'd4; prod = 8'd225; in_valid = 1'b1;
      step();
      acc_len = 4'd1;  // must be ignored mid-batch
      step(); step();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL batch4_early got ov=%b busy=%b need ov=0 busy=1", out_valid, busy);
      end
      step();
      in_valid = 1'b0; prod = 8'd77;
      vectors++;
      if (out_valid !== 1'b1 || acc_out !== 10'd900 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL batch4_result got ov=%b acc=%0d ovf=%b need ov=1 acc=900 ovf=0",
                  out_valid, acc_out, overflow);
      end
      drain();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc_out !== 10'd900 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL batch4_release got ov=%b ir=%b acc=%0d busy=%b need 0 1 900 0",
                  out_valid, in_ready, acc_out, busy);
      end
   endtask

   task automatic test_len_zero();
      acc_len = 4'd0; prod = 8'd6; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || acc_out !== 10'd6 || in_ready !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL len_zero got ov=%b acc=%0d ir=%b busy=%b need 1 6 0 1",
                  out_valid, acc_out, in_ready, busy);
      end
      drain();
   endtask

   task automatic test_back_pressure();
      acc_len = 4'd2; in_valid = 1'b1; prod = 8'd10;
      step();
      prod = 8'd20;
      step();
      in_valid = 1'b1; prod = 8'd99;  // offered while held, must not be taken
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (out_valid !== 1'b1 || acc_out !== 10'd30 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_cycle%0d got ov=%b acc=%0d ir=%b need 1 30 0",
                     i, out_valid, acc_out, in_ready);
         end
         step();
      end
      in_valid = 1'b0;
      drain();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_release got ov=%b ir=%b busy=%b need 0 1 0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_overflow();
      logic [ACC_W-1:0] exp_acc;
`ifdef MULT_ACC_SATURATE_EN
      exp_acc = 10'd1023;
`else
      exp_acc = 10'd101;
`endif
      acc_len = 4'd5; prod = 8'd225; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) step();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || acc_out !== exp_acc || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL overflow got ov=%b acc=%0d ovf=%b need ov=1 acc=%0d ovf=1",
                  out_valid, acc_out, overflow, exp_acc);
      end
      drain();
   endtask

   task automatic test_clear();
      acc_len = 4'd4; in_valid = 1'b1; prod = 8'd5;
      step();
      prod = 8'd7;
      step();
      prod = 8'd100; clear = 1'b1;
      step();
      clear = 1'b0; in_valid = 1'b0;
      vectors++;
      if (acc_out !== 10'd0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL clear got acc=%0d busy=%b ir=%b ov=%b need 0 0 1 0",
                  acc_out, busy, in_ready, out_valid);
      end
      acc_len = 4'd1; prod = 8'd9; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || acc_out !== 10'd9) begin
         miscompares++;
         $display("FAIL after_clear got ov=%b acc=%0d need ov=1 acc=9", out_valid, acc_out);
      end
      drain();
   endtask

   task automatic test_async_reset();
      acc_len = 4'd4; in_valid = 1'b1; prod = 8'd50;
      step(); step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || acc_out !== 10'd0) begin
         miscompares++;
         $display("FAIL async_reset got busy=%b ov=%b acc=%0d need 0 0 0", busy, out_valid, acc_out);
      end
      #2 rst = 1'b0;
      step();
      acc_len = 4'd3; prod = 8'd1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) step();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || acc_out !== 10'd3 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_batch got ov=%b acc=%0d ovf=%b need 1 3 0",
                  out_valid, acc_out, overflow);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_batch4();
      test_len_zero();
      test_back_pressure();
      test_overflow();
      test_clear();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
